cve2_rvfi_trace_streamer: RTL and testbench

CVE2_RVFI_TRACE_STREAMER -- requirements
Module: cve2_rvfi_trace_streamer

---
 rtl/cve2_rvfi_trace_streamer.sv | 76 +++++++
 tb/tb_cve2_rvfi_trace_streamer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/cve2_rvfi_trace_streamer.sv
// cve2_rvfi_trace_streamer: buffers RVFI retire records and streams each as four 32-bit beats
module cve2_rvfi_trace_streamer #(
  parameter int Depth = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        trace_en_i,
  input  logic        rvfi_valid,
  input  logic [31:0] rvfi_pc_rdata,
  input  logic [31:0] rvfi_insn,
  input  logic [4:0]  rvfi_rd_addr,
  input  logic [31:0] rvfi_rd_wdata,
  input  logic        rvfi_trap,
  input  logic        rvfi_intr,
  input  logic [3:0]  rvfi_mem_rmask,
  input  logic [3:0]  rvfi_mem_wmask,
  output logic        trace_valid_o,
  input  logic        trace_ready_i,
  output logic [31:0] trace_data_o,
  output logic        trace_last_o,
  output logic [15:0] drop_count_o
);
  localparam int Aw = $clog2(Depth);
  typedef enum logic [1:0] {HDR, PC, INSN, DATA} beat_e;
  beat_e       beat_q, beat_d;
  logic [Aw:0] wr_q, wr_d, rd_q, rd_d;
  logic [11:0] seq_q, seq_d;
  logic        drop_q, drop_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [31:0] mem_q [Depth][4];
  logic        full, empty, capture, push, drop, accept, pop;
  logic [31:0] hdr;
  assign full    = (wr_q[Aw] != rd_q[Aw]) && (wr_q[Aw-1:0] == rd_q[Aw-1:0]);
  assign empty   = wr_q == rd_q;
  assign capture = rvfi_valid && trace_en_i;
  assign push    = capture && !full;
  assign drop    = capture && full;
  assign accept  = trace_valid_o && trace_ready_i;
  assign pop     = accept && beat_q == DATA;
  assign hdr     = {4'hA, drop_q, rvfi_trap, rvfi_intr, rvfi_rd_addr, rvfi_mem_wmask, rvfi_mem_rmask, seq_q};
  assign trace_valid_o = !empty;
  assign trace_last_o  = trace_valid_o && beat_q == DATA;
  assign trace_data_o  = trace_valid_o ? mem_q[rd_q[Aw-1:0]][beat_q] : 32'd0;
  assign drop_count_o  = drop_cnt_q;
  // next-state: pointers, sequence number, sticky drop flag, saturating drop counter, beat FSM
  always_comb begin
    wr_d       = wr_q + {{Aw{1'b0}}, push};
    rd_d       = rd_q + {{Aw{1'b0}}, pop};
    seq_d      = seq_q + {11'd0, push};
    drop_d     = push ? 1'b0 : (drop ? 1'b1 : drop_q);
    drop_cnt_d = (drop && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
    beat_d     = accept ? beat_e'(beat_q + 2'd1) : beat_q;
  end
  // control state, cleared asynchronously so buffered records vanish at once
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q       <= '0;
      rd_q       <= '0;
      seq_q      <= '0;
      drop_q     <= 1'b0;
      drop_cnt_q <= '0;
      beat_q     <= HDR;
    end else begin
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      seq_q      <= seq_d;
      drop_q     <= drop_d;
      drop_cnt_q <= drop_cnt_d;
      beat_q     <= beat_d;
    end
  end
  // record storage; contents are only observed behind the occupancy pointers, so no reset
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q[Aw-1:0]] <= '{hdr, rvfi_pc_rdata, rvfi_insn, rvfi_rd_wdata};
  end
endmodule

// File: tb/tb_cve2_rvfi_trace_streamer.sv
// tb_cve2_rvfi_trace_streamer: scoreboard bench for the RVFI trace streamer
module tb_cve2_rvfi_trace_streamer;
  localparam int Depth = 4;
  typedef struct {logic [31:0] data; logic last;} beat_t;
  logic        clk = 0, rst_n = 0, en = 0, v = 0, trap = 0, intr = 0, ready = 0;
  logic [31:0] pc = 0, insn = 0, wd = 0;
  logic [4:0]  rd = 0;
  logic [3:0]  rm = 0, wm = 0;
  logic        trace_valid_o, trace_last_o;
  logic [31:0] trace_data_o;
  logic [15:0] drop_count_o;
  beat_t       exp_q[$];
  int          n_cmp = 0, n_err = 0, drops = 0, pushes = 0, rec_pos = 0;
  logic [11:0] seq = 0;
  logic        flag = 0;
  bit          pend_pop = 0;
  logic [31:0] last_hdr = 0;
  cve2_rvfi_trace_streamer #(.Depth(Depth)) dut (
    .clk_i(clk), .rst_ni(rst_n), .trace_en_i(en), .rvfi_valid(v),
    .rvfi_pc_rdata(pc), .rvfi_insn(insn), .rvfi_rd_addr(rd), .rvfi_rd_wdata(wd),
    .rvfi_trap(trap), .rvfi_intr(intr), .rvfi_mem_rmask(rm), .rvfi_mem_wmask(wm),
    .trace_valid_o(trace_valid_o), .trace_ready_i(ready), .trace_data_o(trace_data_o),
    .trace_last_o(trace_last_o), .drop_count_o(drop_count_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] sat_drops();
    return drops > 65535 ? 32'hFFFF : drops;
  endfunction
  // reference model: decides push/drop from its own occupancy and queues expected beats
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      seq = 0; flag = 0; drops = 0; pushes = 0; pend_pop = 0;
    end else begin
      int occ;
      occ = (exp_q.size() + 3) / 4 + int'(pend_pop);
      pend_pop = 0;
      if (v && en) begin
        if (occ < Depth) begin
          exp_q.push_back('{data: {4'hA, flag, trap, intr, rd, wm, rm, seq}, last: 1'b0});
          exp_q.push_back('{data: pc, last: 1'b0});
          exp_q.push_back('{data: insn, last: 1'b0});
          exp_q.push_back('{data: wd, last: 1'b1});
          seq++; pushes++; flag = 0;
        end else begin
          drops++; flag = 1;
        end
      end
    end
  end
  // output checker on the falling edge
  always @(negedge clk) begin
    if (!rst_n) rec_pos = 0;
    else begin
      chk("valid", trace_valid_o, exp_q.size() != 0);
      if (trace_valid_o && exp_q.size() != 0) begin
        chk("data", trace_data_o, exp_q[0].data);
        chk("last", trace_last_o, exp_q[0].last);
        if (ready) begin
          if (rec_pos == 0) last_hdr = trace_data_o;
          rec_pos = (rec_pos + 1) % 4;
          if (exp_q[0].last) pend_pop = 1;
          void'(exp_q.pop_front());
        end
      end else chk("last_idle", trace_last_o, 0);
    end
  end
  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic randomize_fields();
    pc = $urandom; insn = $urandom; wd = $urandom; rd = 5'($urandom);
    trap = 1'($urandom); intr = 1'($urandom); rm = 4'($urandom); wm = 4'($urandom);
  endtask
  task automatic retire(input logic [31:0] p, input logic [31:0] i, input logic [31:0] w, input logic [4:0] r);
    pc = p; insn = i; wd = w; rd = r; trap = 0; intr = 0; rm = 0; wm = 0; v = 1;
    cyc();
    v = 0;
  endtask
  task automatic drain(input int budget);
    for (int i = 0; i < budget && (exp_q.size() != 0 || pend_pop); i++) cyc();
    chk("drain", exp_q.size(), 0);
  endtask
  task automatic do_reset();
    rst_n = 0;
    cyc(2);
    rst_n = 1;
    cyc();
  endtask
  initial begin
    cyc(2);
    chk("rst_valid", trace_valid_o, 0);
    chk("rst_last", trace_last_o, 0);
    chk("rst_data", trace_data_o, 0);
    chk("rst_drops", drop_count_o, 0);
    rst_n = 1; en = 1; ready = 1;
    cyc();
    retire(32'h8000_0000, 32'h00A0_0093, 32'h0000_000A, 5'd1);
    drain(20);
    chk("single_hdr", last_hdr, 32'hA010_0000);
    retire(32'h8000_0004, 32'h0010_0113, 32'h1234_5678, 5'd2);
    for (int i = 0; i < 20 && exp_q.size() != 2; i++) cyc();
    ready = 0;
    cyc(5);
    chk("bp_valid_held", trace_valid_o, 1);
    ready = 1;
    drain(20);
    do_reset();
    ready = 0;
    for (int i = 0; i < 6; i++) retire(32'h100 + 4 * i, 32'h13 + i, i, 5'(i + 3));
    chk("ovf_drops", drop_count_o, 2);
    chk("ovf_drops_model", drop_count_o, sat_drops());
    ready = 1;
    drain(40);
    retire(32'h200, 32'h33, 32'h55, 5'd7);
    drain(20);
    chk("ovf_flag", last_hdr[27], 1);
    chk("ovf_seq", last_hdr[11:0], 4);
    en = 0;
    for (int i = 0; i < 3; i++) retire(32'h300, 32'h13, 0, 5'd1);
    chk("en_off", trace_valid_o, 0);
    en = 1;
    for (int i = 0; i < 400; i++) begin
      randomize_fields();
      v = 1'($urandom);
      ready = $urandom_range(0, 3) != 0;
      en = $urandom_range(0, 7) != 0;
      cyc();
    end
    v = 0; ready = 1; en = 1;
    drain(200);
    chk("rand_drops", drop_count_o, sat_drops());
    retire(32'h400, 32'h13, 32'h1, 5'd1);
    for (int i = 0; i < 20 && exp_q.size() != 2; i++) cyc();
    rst_n = 0;
    #1;
    chk("amid_valid", trace_valid_o, 0);
    chk("amid_last", trace_last_o, 0);
    chk("amid_data", trace_data_o, 0);
    cyc();
    rst_n = 1;
    cyc();
    retire(32'h500, 32'h93, 32'h2, 5'd3);
    drain(20);
    chk("post_rst_seq", last_hdr[11:0], 0);
    chk("post_rst_flag", last_hdr[27], 0);
    v = 1;
    for (int i = 0; i < 20000 && pushes < 4097; i++) begin
      randomize_fields();
      cyc();
    end
    v = 0;
    drain(20);
    chk("wrap_count", pushes, 4097);
    chk("wrap_seq", last_hdr[11:0], 0);
    chk("wrap_drops", drop_count_o, sat_drops());
    ready = 0; v = 1;
    for (int i = 0; i < 70000 && drops < 65537; i++) cyc();
    v = 0;
    chk("sat_model", sat_drops(), 32'hFFFF);
    chk("sat_drops", drop_count_o, 16'hFFFF);
    ready = 1;
    drain(40);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
